// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the 2D-conv pixel streaming path.
package conv2d_pkg;

    localparam int unsigned PIXEL_W = 16;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Zero beats needed for the window stage to drain its last windows.
    function automatic int unsigned flush_len(input int unsigned filt_dim,
                                              input int unsigned in_width);
        return (filt_dim / 2) * in_width + filt_dim / 2;
    endfunction

endpackage

// File: rtl/conv2d_frame_ram.sv
// Frame store: one write port, one synchronous read port whose read register
// doubles as the streamer's output pixel register (clearable for flush beats).
module conv2d_frame_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write on an address collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv2d_pixel_streamer.sv
// Streams a stored square feature map in raster order followed by zero flush
// beats, one pixel per accepted beat, into the sliding-window stage.
module conv2d_pixel_streamer
    import conv2d_pkg::*;
#(
    parameter int unsigned bitWidth      = 16,
    parameter int unsigned inputWidth    = 8,
    parameter int unsigned filtDimension = 3
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      wrEn,
    input  logic [$clog2(inputWidth*inputWidth)-1:0]  wrAddr,
    input  logic signed [bitWidth-1:0]                wrData,
    input  logic                                      start,
    input  logic                                      outReady,
    output logic signed [bitWidth-1:0]                outputPixel,
    output logic                                      pixelValid,
    output logic                                      lastPixel,
    output logic [$clog2(inputWidth)-1:0]             rowIdx,
    output logic [$clog2(inputWidth)-1:0]             colIdx,
    output logic                                      busy,
    output logic                                      done
);

    localparam int unsigned DEPTH     = inputWidth * inputWidth;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned FLUSH_LEN = flush_len(filtDimension, inputWidth);
    localparam int unsigned IDX_W     = $clog2(DEPTH + FLUSH_LEN);
    localparam int unsigned RC_W      = $clog2(inputWidth);
    localparam int unsigned LAST_IDX  = DEPTH + FLUSH_LEN - 1;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n, idx_inc;
    logic [RC_W-1:0]   row_q, row_n, col_q, col_n;
    logic              valid_q, valid_n;
    logic              last_q, last_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              accept;
    logic              ram_we, ram_re, ram_clr;
    logic [AW-1:0]     ram_raddr;
    logic [bitWidth-1:0] ram_rdata;

    assign accept  = valid_q && outReady;
    assign idx_inc = idx_q + IDX_W'(1);
    // The frame is frozen while it is being streamed.
    assign ram_we  = wrEn && ((state_q == IDLE) || (state_q == DONE));

    conv2d_frame_ram #(
        .DATA_W (bitWidth),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_frame_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (ram_we),
        .wr_addr (wrAddr),
        .wr_data (wrData),
        .rd_en   (ram_re),
        .rd_clr  (ram_clr),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            row_q   <= row_n;
            col_q   <= col_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        row_n     = row_q;
        col_n     = col_q;
        valid_n   = valid_q;
        last_n    = last_q;
        done_n    = 1'b0;
        ram_re    = 1'b0;
        ram_clr   = 1'b0;
        ram_raddr = idx_inc[AW-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n   = STREAM;
                    idx_n     = '0;
                    row_n     = '0;
                    col_n     = '0;
                    valid_n   = 1'b1;
                    last_n    = 1'b0;
                    ram_re    = 1'b1;
                    ram_raddr = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    idx_n = idx_inc;
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_n = FLUSH;
                        ram_clr = 1'b1;
                        row_n   = '0;
                        col_n   = '0;
                        last_n  = (FLUSH_LEN == 1);
                    end else begin
                        ram_re = 1'b1;
                        if (col_q == RC_W'(inputWidth - 1)) begin
                            col_n = '0;
                            row_n = row_q + RC_W'(1);
                        end else begin
                            col_n = col_q + RC_W'(1);
                        end
                    end
                end
            end
            FLUSH: begin
                if (accept) begin
                    if (last_q) begin
                        state_n = DONE;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n  = idx_inc;
                        last_n = (idx_inc == IDX_W'(LAST_IDX));
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == STREAM) || (state_n == FLUSH);
    end

    assign outputPixel = ram_rdata;
    assign pixelValid  = valid_q;
    assign lastPixel   = last_q;
    assign rowIdx      = row_q;
    assign colIdx      = col_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv2d_pixel_streamer.sv
// Self-checking bench for conv2d_pixel_streamer: table of frame runs plus a
// scoreboard of expected beats checked on every accepted handshake.
module tb_conv2d_pixel_streamer;
    import conv2d_pkg::*;

    localparam int BW    = 16;
    localparam int IW    = 8;
    localparam int FD    = 3;
    localparam int DEPTH = IW * IW;
    localparam int FLEN  = (FD / 2) * IW + FD / 2;
    localparam int TOTAL = DEPTH + FLEN;

    logic              clock = 1'b0;
    logic              reset;
    logic              wrEn;
    logic [5:0]        wrAddr;
    logic signed [BW-1:0] wrData;
    logic              start;
    logic              outReady;
    logic signed [BW-1:0] outputPixel;
    logic              pixelValid;
    logic              lastPixel;
    logic [2:0]        rowIdx;
    logic [2:0]        colIdx;
    logic              busy;
    logic              done;

    conv2d_pixel_streamer #(
        .bitWidth      (BW),
        .inputWidth    (IW),
        .filtDimension (FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .start       (start),
        .outReady    (outReady),
        .outputPixel (outputPixel),
        .pixelValid  (pixelValid),
        .lastPixel   (lastPixel),
        .rowIdx      (rowIdx),
        .colIdx      (colIdx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pattern;     // -1 keeps the current frame contents
        int stall_at;    // beats accepted before outReady is dropped
        int stall_len;
        int inject_at;   // beat at which start+wrEn are pulsed mid-stream
        int reset_at;    // beat at which reset is asserted
        int exp_accepts;
    } vec_t;

    vec_t       vecs [7];
    pixel_t     model_mem [DEPTH];
    logic [22:0] sb [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         beats_seen = 0;
    logic       prev_stall = 1'b0;
    logic [22:0] prev_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (beat %0d)", name, act, exp, beats_seen);
        end
    endtask

    // Accepted beats are popped from the scoreboard; stalled beats must hold.
    always @(negedge clock) begin
        logic [22:0] bus;
        bus = {outputPixel, lastPixel, rowIdx, colIdx};
        if (reset) begin
            if (prev_stall) chk("hold_stable", 32'(bus), 32'(prev_bus));
            if (pixelValid) chk("busy_while_valid", 32'(busy), 32'd1);
            if (pixelValid && outReady) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("beat", 32'(bus), 32'(sb.pop_front()));
                end
                beats_seen++;
            end
            prev_stall = pixelValid && !outReady;
            prev_bus   = bus;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic write_px(input int addr, input pixel_t val);
        wrEn   = 1'b1;
        wrAddr = 6'(addr);
        wrData = val;
        @(posedge clock); #1;
        wrEn   = 1'b0;
        model_mem[addr] = val;
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < DEPTH; i++) begin
            pixel_t v;
            case (pat)
                1:       v = (i == 5) ? 16'sh8000 : (i == 6) ? 16'shFFFF : 16'(i);
                2:       v = 16'($urandom);
                default: v = 16'(i);
            endcase
            write_px(i, v);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < TOTAL; i++) begin
            if (i < DEPTH) sb.push_back({model_mem[i], 1'b0, 3'(i / IW), 3'(i % IW)});
            else           sb.push_back({16'h0000, (i == TOTAL - 1), 3'd0, 3'd0});
        end
    endtask

    task automatic run_frame(input vec_t v);
        int  stalled;
        bit  injected;
        bit  seen_done;
        push_frame();
        beats_seen = 0;
        stalled    = 0;
        injected   = 1'b0;
        seen_done  = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("start_latency_valid", 32'(pixelValid), 32'd1);
        for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
            outReady = !(beats_seen == v.stall_at && stalled < v.stall_len);
            if (!outReady) stalled++;
            if (v.inject_at >= 0 && !injected && beats_seen == v.inject_at) begin
                start    = 1'b1;
                wrEn     = 1'b1;
                wrAddr   = 6'd3;
                wrData   = 16'sh7777;
                injected = 1'b1;
            end
            if (v.reset_at >= 0 && beats_seen == v.reset_at) begin
                #1 reset = 1'b0;
                #1;
                chk("rst_pixel", 32'(outputPixel), 32'd0);
                chk("rst_valid", 32'(pixelValid), 32'd0);
                chk("rst_last",  32'(lastPixel), 32'd0);
                chk("rst_rowcol", 32'({rowIdx, colIdx}), 32'd0);
                chk("rst_busy",  32'(busy), 32'd0);
                chk("rst_accepts", 32'(beats_seen), 32'(v.exp_accepts));
                sb.delete();
                @(posedge clock); #1;
                reset    = 1'b1;
                outReady = 1'b1;
                return;
            end
            @(posedge clock); #1;
            start = 1'b0;
            wrEn  = 1'b0;
            if (done) seen_done = 1'b1;
        end
        outReady = 1'b1;
        if (!seen_done) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        chk("accepts_at_done", 32'(beats_seen), 32'(v.exp_accepts));
        chk("valid_low_at_done", 32'(pixelValid), 32'd0);
        chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
        @(posedge clock); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{pattern: 0,  stall_at: -1, stall_len: 0, inject_at: -1, reset_at: -1, exp_accepts: TOTAL};
        vecs[1] = '{pattern: 0,  stall_at: 9,  stall_len: 3, inject_at: -1, reset_at: -1, exp_accepts: TOTAL};
        vecs[2] = '{pattern: 1,  stall_at: -1, stall_len: 0, inject_at: -1, reset_at: -1, exp_accepts: TOTAL};
        vecs[3] = '{pattern: 0,  stall_at: 67, stall_len: 2, inject_at: 20, reset_at: -1, exp_accepts: TOTAL};
        vecs[4] = '{pattern: -1, stall_at: -1, stall_len: 0, inject_at: -1, reset_at: -1, exp_accepts: TOTAL};
        vecs[5] = '{pattern: 2,  stall_at: 30, stall_len: 1, inject_at: -1, reset_at: 30, exp_accepts: 30};
        vecs[6] = '{pattern: -1, stall_at: 72, stall_len: 4, inject_at: -1, reset_at: -1, exp_accepts: TOTAL};

        reset    = 1'b0;
        wrEn     = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        start    = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_pixel", 32'(outputPixel), 32'd0);
        chk("reset_valid", 32'(pixelValid), 32'd0);
        chk("reset_last",  32'(lastPixel), 32'd0);
        chk("reset_row",   32'(rowIdx), 32'd0);
        chk("reset_col",   32'(colIdx), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_done",  32'(done), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].pattern >= 0) load_pattern(vecs[k].pattern);
            run_frame(vecs[k]);
        end

        // Rewriting in IDLE must take effect on the next frame.
        write_px(3, 16'sh7777);
        chk("idle_no_valid", 32'(pixelValid), 32'd0);
        run_frame('{pattern: -1, stall_at: -1, stall_len: 0, inject_at: -1, reset_at: -1, exp_accepts: TOTAL});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
